// File: rtl/seg_scan.sv
// Multiplexed 7-segment scanner with shadow/active double-buffered digit banks.
// Optional build macro: SEG_SCAN_GHOST_BLANK_EN blanks the first cycle of every digit slot.
module seg_scan #(
    parameter int N_DIG = 4,
    parameter int DIV   = 1000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             EN,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [2:0]       wr_idx,
    input  logic [6:0]       wr_seg,
    input  logic             commit,
    output logic [6:0]       seg_out,
    output logic [N_DIG-1:0] an,
    output logic             frame_tick
);
    localparam logic [15:0] CNT_LAST = 16'(DIV - 1);
    localparam logic [2:0]  IDX_LAST = 3'(N_DIG - 1);
    localparam int          BANK_W   = N_DIG * 7;

    logic [15:0]       cnt_q, cnt_d;
    logic [2:0]        idx_q, idx_d;
    logic              pending_q, pending_d;
    logic [BANK_W-1:0] shadow_q, shadow_d;
    logic [BANK_W-1:0] active_q, active_d;
    logic [6:0]        seg_out_q, seg_out_d;
    logic [N_DIG-1:0]  an_q, an_d;

    logic              slot_end;
    logic              frame_end;
    logic              wr_fire;
    logic              publish;
    logic              drive;
    logic [6:0]        seg_sel;
    logic [N_DIG-1:0]  onehot;

    assign slot_end   = (cnt_q == CNT_LAST);
    assign frame_end  = slot_end && (idx_q == IDX_LAST);
    assign wr_ready   = ~pending_q;
    assign wr_fire    = wr_valid & wr_ready;
    assign publish    = frame_end & (pending_q | commit);
    assign frame_tick = frame_end;

    always_comb begin
        cnt_d = slot_end ? 16'd0 : cnt_q + 16'd1;
        idx_d = idx_q;
        if (slot_end) begin
            idx_d = (idx_q == IDX_LAST) ? 3'd0 : idx_q + 3'd1;
        end
        pending_d = publish ? 1'b0 : (pending_q | commit);
    end

    genvar gi;
    generate
        for (gi = 0; gi < N_DIG; gi++) begin : g_digit
            // An out-of-range wr_idx matches no digit: the write is accepted and dropped.
            assign shadow_d[gi*7 +: 7] = (wr_fire && (wr_idx == 3'(gi))) ? wr_seg
                                                                         : shadow_q[gi*7 +: 7];
            // Publishing takes shadow_d so a same-edge write lands in the snapshot.
            assign active_d[gi*7 +: 7] = publish ? shadow_d[gi*7 +: 7] : active_q[gi*7 +: 7];
            assign onehot[gi]          = (idx_q == 3'(gi));
        end
    endgenerate

    always_comb begin
        seg_sel = 7'd0;
        for (int i = 0; i < N_DIG; i++) begin
            if (onehot[i]) begin
                seg_sel = active_q[i*7 +: 7];
            end
        end
    end

`ifdef SEG_SCAN_GHOST_BLANK_EN
    assign drive = EN && (cnt_q != 16'd0);
`else
    assign drive = EN;
`endif

    always_comb begin
        an_d      = drive ? onehot  : '0;
        seg_out_d = drive ? seg_sel : 7'd0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= 16'd0;
            idx_q     <= 3'd0;
            pending_q <= 1'b0;
            shadow_q  <= '0;
            active_q  <= '0;
            seg_out_q <= 7'd0;
            an_q      <= '0;
        end else begin
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            pending_q <= pending_d;
            shadow_q  <= shadow_d;
            active_q  <= active_d;
            seg_out_q <= seg_out_d;
            an_q      <= an_d;
        end
    end

    assign seg_out = seg_out_q;
    assign an      = an_q;

endmodule

// File: tb/tb_seg_scan.sv
// Bench for seg_scan (N_DIG=4, DIV=4): time-indexed reference model plus directed and random stimulus.
module tb_seg_scan;
    localparam int N = 4;
    localparam int D = 4;
    localparam int F = N * D;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       EN = 1'b1;
    logic       wr_valid = 1'b0;
    logic [2:0] wr_idx = 3'd0;
    logic [6:0] wr_seg = 7'd0;
    logic       commit = 1'b0;
    logic       wr_ready;
    logic [6:0] seg_out;
    logic [3:0] an;
    logic       frame_tick;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seg_scan #(.N_DIG(N), .DIV(D)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .EN         (EN),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_idx     (wr_idx),
        .wr_seg     (wr_seg),
        .commit     (commit),
        .seg_out    (seg_out),
        .an         (an),
        .frame_tick (frame_tick)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: scan position derived purely from cycles elapsed since reset.
    int         m_t;
    bit         m_pending;
    logic [6:0] m_shadow [N];
    logic [6:0] m_active [N];
    logic [3:0] m_an;
    logic [6:0] m_seg;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_t       = 0;
            m_pending = 1'b0;
            for (int i = 0; i < N; i++) begin
                m_shadow[i] = 7'd0;
                m_active[i] = 7'd0;
            end
            m_an  = 4'd0;
            m_seg = 7'd0;
        end else begin
            int  pos;
            int  digit;
            bit  blank;
            pos   = m_t % D;
            digit = (m_t / D) % N;
            blank = !EN;
`ifdef SEG_SCAN_GHOST_BLANK_EN
            blank = blank || (pos == 0);
`endif
            m_an  = blank ? 4'd0 : 4'(1 << digit);
            m_seg = blank ? 7'd0 : m_active[digit];
            if (wr_valid && !m_pending && (int'(wr_idx) < N))
                m_shadow[int'(wr_idx)] = wr_seg;
            if (commit)
                m_pending = 1'b1;
            if ((m_t % F) == F - 1 && m_pending) begin
                m_active  = m_shadow;
                m_pending = 1'b0;
            end
            m_t++;
        end
    end

    always @(negedge clk) begin
        chk("an", 32'(an), 32'(m_an));
        chk("seg_out", 32'(seg_out), 32'(m_seg));
        chk("wr_ready", 32'(wr_ready), 32'(!m_pending));
        chk("frame_tick", 32'(frame_tick), 32'((m_t % F) == F - 1));
    end

    task automatic wait_t(input int n);
        int guard;
        guard = 0;
        while (m_t != n && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        if (m_t != n) chk("wait_t", 32'(m_t), 32'(n));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_an", 32'(an), 32'd0);
        chk("rst_seg", 32'(seg_out), 32'd0);
        chk("rst_ready", 32'(wr_ready), 32'd1);
        chk("rst_tick", 32'(frame_tick), 32'd0);
        rst_n = 1'b1;

        // Idle scan with blank banks
        wait_t(2);  chk("scan_d0", 32'(an), 32'b0001);
        wait_t(6);  chk("scan_d1", 32'(an), 32'b0010);
        wait_t(10); chk("scan_d2", 32'(an), 32'b0100);
        wait_t(13); chk("scan_seg0", 32'(seg_out), 32'd0);
        wait_t(14); chk("scan_d3", 32'(an), 32'b1000);
        chk("tick_low", 32'(frame_tick), 32'd0);
        wait_t(15); chk("tick_high", 32'(frame_tick), 32'd1);

        // Write digit 1, commit mid-frame
        wait_t(16); wr_valid = 1'b1; wr_idx = 3'd1; wr_seg = 7'b0110000;
        wait_t(17); wr_valid = 1'b0; commit = 1'b1;
        wait_t(18); commit = 1'b0; chk("pend_ready", 32'(wr_ready), 32'd0);
        wait_t(32); chk("pub_ready", 32'(wr_ready), 32'd1);
        wait_t(38); chk("d1_an", 32'(an), 32'b0010); chk("d1_seg", 32'(seg_out), 32'b0110000);

        // Write + commit on the frame-boundary cycle
        wait_t(47); wr_valid = 1'b1; wr_idx = 3'd2; wr_seg = 7'b1011011; commit = 1'b1;
        wait_t(48); wr_valid = 1'b0; commit = 1'b0; chk("bnd_ready", 32'(wr_ready), 32'd1);
        wait_t(58); chk("d2_an", 32'(an), 32'b0100); chk("d2_seg", 32'(seg_out), 32'b1011011);

        // Out-of-range index is accepted and dropped
        wait_t(60); wr_valid = 1'b1; wr_idx = 3'd5; wr_seg = 7'h7F;
        wait_t(61); chk("oor_ready", 32'(wr_ready), 32'd1); wr_valid = 1'b0; commit = 1'b1;
        wait_t(62); commit = 1'b0; chk("oor_pend", 32'(wr_ready), 32'd0);
        wait_t(66); chk("oor_d0", 32'(seg_out), 32'd0);
        wait_t(70); chk("oor_d1", 32'(seg_out), 32'b0110000);

        // EN low for three cycles
        wait_t(72); chk("en_before", 32'(an), 32'b0010); EN = 1'b0;
        wait_t(73); chk("en_off0", 32'(an), 32'd0);
        wait_t(75); chk("en_off2", 32'(an), 32'd0); chk("en_off2_seg", 32'(seg_out), 32'd0); EN = 1'b1;
        wait_t(76); chk("en_after", 32'(an), 32'b0100);

        // Reset while a commit is pending
        wait_t(80); wr_valid = 1'b1; wr_idx = 3'd3; wr_seg = 7'h7F; commit = 1'b1;
        wait_t(81); wr_valid = 1'b0; commit = 1'b0; chk("rc_pend", 32'(wr_ready), 32'd0);
        wait_t(82);
        #1 rst_n = 1'b0;
        #1;
        chk("rc_ready", 32'(wr_ready), 32'd1);
        chk("rc_an", 32'(an), 32'd0);
        chk("rc_seg", 32'(seg_out), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        wait_t(6);  chk("rc_d1_clr", 32'(seg_out), 32'd0);
        wait_t(14); chk("rc_d3_lost", 32'(seg_out), 32'd0);

        // Randomized traffic with occasional reset pulses
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            wr_valid = 1'($urandom_range(0, 1));
            wr_idx   = 3'($urandom_range(0, 7));
            wr_seg   = 7'($urandom);
            commit   = ($urandom_range(0, 7) == 0);
            EN       = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 599) == 0) begin
                #2 rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
            end
        end
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
